lambert_shader_pipe: RTL
========================

Name: lambert_shader_pipe

Overview:
- Parametrised successor to the single-ray diffuse shader. Per job: reconstructs the hit point p = orig + dir*t, forms the light vector L = light - p, and computes Lambert intensity dot(L,n) / (|L|*|n|).
- Emits a per-channel RGB colour as albedo * intensity plus an ambient floor.
- Replaces the free-running counter sequencing with a valid/ready handshake, deterministic latency, a fast path for back-facing and miss cases, backpressure, and generic widths.
- Sits between the intersection stage and the framebuffer writer.

Parameters:
COORD_W, 10, unsigned width of each coordinate component (orig, light) and of normal_len
DIR_W, 10, signed width of each dir and normal component
T_W, 10, unsigned width of t
DIR_SHIFT, 5, fixed-point fraction bits of dir*t (arithmetic right shift)
I_W, 4, intensity fraction bits; intensity range 0..2^I_W-1
CH_W, 4, bits per colour channel
AMBIENT, 1, additive ambient term per channel for lit and back-facing hits

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  job offered
in_ready  out  1  block idle, job accepted when in_valid&in_ready at posedge
hit  in  1  1 = ray hit, 0 = miss
orig  in  3*COORD_W  ray origin {x,y,z}, x in MSBs
dir  in  3*DIR_W  signed ray direction {x,y,z}
t  in  T_W  hit distance
light  in  3*COORD_W  light position {x,y,z}
normal  in  3*DIR_W  signed surface normal {x,y,z}
normal_len  in  COORD_W  precomputed |normal|
albedo  in  3*CH_W  surface colour {r,g,b}
out_valid  out  1  colour valid
out_ready  in  1  consumer accepts colour
color  out  3*CH_W  shaded colour {r,g,b}

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE, out_valid=0, color=0.
  - in_ready=0 while rst is low. in_ready = rst & (state==IDLE).
  - Reset mid-job aborts the job; no output is produced.
- States: IDLE, HITP, VEC, SQRT, DEN, DIV, SHADE, OUT.
- Accept edge (edge 0): all inputs registered; state goes to HITP.
- Edge 1, HITP: p_k = orig_k + ((dir_k*t) >>> DIR_SHIFT).
  - Signed arithmetic shift, floor toward -inf.
  - Internal width COORD_W+DIR_W+T_W+1.
- Edge 2, VEC:
  - l_k = light_k - p_k, saturated to L_W = COORD_W+2 signed.
  - dot = sum l_k*n_k, signed.
  - sq = sum l_k^2, unsigned, 2*L_W+2 bits.
  - If hit=0 or dot<=0, go to SHADE (fast path). Otherwise go to SQRT.
- SQRT: bit-serial restoring integer square root, len = floor(sqrt(sq)). Takes exactly SQ_IT = L_W+1 edges (13 at defaults).
- DEN, 1 edge:
  - den = len*normal_len.
  - sat = (dot >= den).
  - If den=0, intensity = 0.
- DIV: restoring division q = floor((dot<<I_W)/den). Takes exactly I_W edges, executed even when sat or den=0, to keep latency fixed.
- Intensity:
  - 2^I_W-1 when sat=1 and den!=0.
  - q otherwise.
  - 0 on the fast path.
- SHADE, 1 edge:
  - hit=0: color = 0.
  - Else color_c = min(2^CH_W-1, AMBIENT + ((albedo_c*intensity) >> I_W)).
  - out_valid is set to 1 and state goes to OUT.
- Latency: out_valid rises on edge 4+SQ_IT+I_W after the accept edge (21 at defaults). Fast path: edge 3.
- OUT:
  - color and out_valid are held stable until out_valid&out_ready at a posedge.
  - On that edge out_valid=0 and state goes to IDLE.
  - in_ready rises after that edge; no same-cycle accept.
  - Throughput: one job per latency+2 cycles minimum.
- in_valid is ignored when in_ready=0. Input changes after the accept edge do not affect the job in flight.
- out_ready high before out_valid has no effect.

Test Plan:
- Defaults; orig=(0,0,0), dir=(32,0,0), t=10, light=(10,0,20), normal=(0,0,16), normal_len=16, albedo=(15,15,15), hit=1 -> dot=320, len=20, den=320, sat; color=(15,15,15); out_valid on edge 21.
- Same but light=(10,12,16), albedo=(15,8,0) -> len=20, q=floor(4096/320)=12; color=(12,7,1) on edge 21.
- normal=(16,0,0), otherwise as the first case -> dot=0, fast path; color=(1,1,1) on edge 3. Then hit=0 -> color=(0,0,0) on edge 3.
- Negative dir=(-32,0,0), orig=(20,0,0), rest as the first case -> p=(10,0,0), color=(15,15,15). Also dir=(-1,0,0), t=1 -> p_x=orig_x-1 (floor shift).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> color stable, in_ready=0, a second in_valid is not accepted. Release -> one transfer, in_ready=1 next cycle, second job accepted.
- Deassert rst at edge 8 of a full-path job -> out_valid=0, color=0 immediately. After release in_ready=1, no stale output, and a new job completes correctly.

Source files
------------

// File: rtl/lambert_shader_pipe.sv
// Multi-cycle Lambert diffuse shader with a valid/ready handshake and fixed latency.
// Rebuilds the hit point, forms the light vector and emits albedo*intensity plus an ambient floor.
`timescale 1ns/1ps
module lambert_shader_pipe #(
  parameter int COORD_W   = 10,
  parameter int DIR_W     = 10,
  parameter int T_W       = 10,
  parameter int DIR_SHIFT = 5,
  parameter int I_W       = 4,
  parameter int CH_W      = 4,
  parameter int AMBIENT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 hit,
  input  logic [3*COORD_W-1:0] orig,
  input  logic [3*DIR_W-1:0]   dir,
  input  logic [T_W-1:0]       t,
  input  logic [3*COORD_W-1:0] light,
  input  logic [3*DIR_W-1:0]   normal,
  input  logic [COORD_W-1:0]   normal_len,
  input  logic [3*CH_W-1:0]    albedo,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*CH_W-1:0]    color
);
  localparam int IW    = COORD_W + DIR_W + T_W + 1;
  localparam int L_W   = COORD_W + 2;
  localparam int DOT_W = L_W + DIR_W + 2;
  localparam int SQ_W  = 2 * L_W + 2;
  localparam int SQ_IT = L_W + 1;
  localparam int RT_W  = L_W + 1;
  localparam int REM_W = RT_W + 2;
  localparam int DEN_W = RT_W + COORD_W;
  localparam int DIV_W = DEN_W + 1;
  localparam int CMP_W = DOT_W + DEN_W;
  localparam logic signed [IW-1:0] L_MAX = IW'((2 ** (L_W - 1)) - 1);
  localparam logic signed [IW-1:0] L_MIN = -IW'(2 ** (L_W - 1));

  typedef enum logic [2:0] {IDLE, HITP, VEC, SQRT, DEN, DIV, SHADE, OUT} state_t;

  state_t                     state_q, state_d;
  logic                       hit_q, hit_d, fast_q, fast_d, sat_q, sat_d;
  logic                       out_valid_q, out_valid_d;
  logic        [COORD_W-1:0]  orig_q [3], orig_d [3], light_q [3], light_d [3];
  logic signed [DIR_W-1:0]    dir_q [3], dir_d [3], normal_q [3], normal_d [3];
  logic        [CH_W-1:0]     albedo_q [3], albedo_d [3], color_q [3], color_d [3];
  logic signed [IW-1:0]       p_q [3], p_d [3];
  logic        [T_W-1:0]      t_q, t_d;
  logic        [COORD_W-1:0]  nlen_q, nlen_d;
  logic signed [DOT_W-1:0]    dot_q, dot_d;
  logic        [SQ_W-1:0]     rad_q, rad_d;
  logic        [REM_W-1:0]    rem_q, rem_d;
  logic        [RT_W-1:0]     root_q, root_d;
  logic        [7:0]          cnt_q, cnt_d;
  logic        [DEN_W-1:0]    den_q, den_d;
  logic        [DIV_W-1:0]    drem_q, drem_d;
  logic        [I_W-1:0]      quo_q, quo_d;

  logic signed [IW-1:0]       prod [3], shv [3], diff [3];
  logic signed [L_W-1:0]      lv [3];
  logic signed [DOT_W-1:0]    le [3], ne [3], dot_sum;
  logic signed [SQ_W-1:0]     ls [3];
  logic        [SQ_W-1:0]     sq;
  logic        [REM_W-1:0]    rem_sh, trial;
  logic        [DIV_W-1:0]    dsh;
  logic        [I_W-1:0]      intens;
  logic        [31:0]         shade [3];

  assign in_ready  = rst & (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign color     = {color_q[0], color_q[1], color_q[2]};

  always_comb begin
    state_d = state_q;  hit_d = hit_q;  fast_d = fast_q;  sat_d = sat_q;
    out_valid_d = out_valid_q;  t_d = t_q;  nlen_d = nlen_q;  dot_d = dot_q;
    rad_d = rad_q;  rem_d = rem_q;  root_d = root_q;  cnt_d = cnt_q;
    den_d = den_q;  drem_d = drem_q;  quo_d = quo_q;
    for (int k = 0; k < 3; k++) begin
      orig_d[k] = orig_q[k];  light_d[k] = light_q[k];  dir_d[k] = dir_q[k];
      normal_d[k] = normal_q[k];  albedo_d[k] = albedo_q[k];  color_d[k] = color_q[k];
      p_d[k] = p_q[k];
      prod[k] = IW'(dir_q[k]) * $signed(IW'(t_q));
      shv[k]  = prod[k] >>> DIR_SHIFT;
      diff[k] = $signed(IW'(light_q[k])) - p_q[k];
      if (diff[k] > L_MAX)      lv[k] = L_MAX[L_W-1:0];
      else if (diff[k] < L_MIN) lv[k] = L_MIN[L_W-1:0];
      else                      lv[k] = diff[k][L_W-1:0];
      le[k] = lv[k];
      ne[k] = normal_q[k];
      ls[k] = lv[k];
    end
    dot_sum = le[0] * ne[0] + le[1] * ne[1] + le[2] * ne[2];
    sq      = $unsigned(ls[0] * ls[0] + ls[1] * ls[1] + ls[2] * ls[2]);
    rem_sh  = REM_W'({rem_q, rad_q[SQ_W-1 -: 2]});
    trial   = {root_q, 2'b01};
    dsh     = DIV_W'({drem_q, 1'b0});
    if (fast_q || den_q == '0) intens = '0;
    else if (sat_q)            intens = '1;
    else                       intens = quo_q;
    for (int c = 0; c < 3; c++) begin
      shade[c] = ((32'(albedo_q[c]) * 32'(intens)) >> I_W) + 32'(AMBIENT);
    end

    case (state_q)
      IDLE: if (in_valid) begin
        hit_d = hit;  t_d = t;  nlen_d = normal_len;
        for (int k = 0; k < 3; k++) begin
          orig_d[k]   = orig[3*COORD_W-1-k*COORD_W -: COORD_W];
          light_d[k]  = light[3*COORD_W-1-k*COORD_W -: COORD_W];
          dir_d[k]    = $signed(dir[3*DIR_W-1-k*DIR_W -: DIR_W]);
          normal_d[k] = $signed(normal[3*DIR_W-1-k*DIR_W -: DIR_W]);
          albedo_d[k] = albedo[3*CH_W-1-k*CH_W -: CH_W];
        end
        state_d = HITP;
      end
      HITP: begin
        for (int k = 0; k < 3; k++) p_d[k] = $signed(IW'(orig_q[k])) + shv[k];
        state_d = VEC;
      end
      VEC: begin
        dot_d  = dot_sum;
        fast_d = !hit_q || (dot_sum <= 0);
        rad_d  = sq;  rem_d = '0;  root_d = '0;  cnt_d = '0;
        state_d = (!hit_q || (dot_sum <= 0)) ? SHADE : SQRT;
      end
      // One result bit per edge: bring down two radicand bits, try subtracting 4*root+1.
      SQRT: begin
        rad_d = {rad_q[SQ_W-3:0], 2'b00};
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = RT_W'({root_q, 1'b1});
        end else begin
          rem_d  = rem_sh;
          root_d = RT_W'({root_q, 1'b0});
        end
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(SQ_IT - 1)) state_d = DEN;
      end
      DEN: begin
        den_d  = DEN_W'(root_q) * DEN_W'(nlen_q);
        sat_d  = CMP_W'($unsigned(dot_q)) >= CMP_W'(DEN_W'(root_q) * DEN_W'(nlen_q));
        drem_d = DIV_W'($unsigned(dot_q));
        quo_d  = '0;  cnt_d = '0;
        state_d = DIV;
      end
      // Runs the full count even when the result is overridden, so latency never varies.
      DIV: begin
        if (dsh >= DIV_W'(den_q)) begin
          drem_d = dsh - DIV_W'(den_q);
          quo_d  = I_W'({quo_q, 1'b1});
        end else begin
          drem_d = dsh;
          quo_d  = I_W'({quo_q, 1'b0});
        end
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(I_W - 1)) state_d = SHADE;
      end
      SHADE: begin
        for (int c = 0; c < 3; c++) begin
          if (!hit_q)                              color_d[c] = '0;
          else if (shade[c] > 32'((2 ** CH_W) - 1)) color_d[c] = '1;
          else                                     color_d[c] = CH_W'(shade[c]);
        end
        out_valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;  hit_q <= 1'b0;  fast_q <= 1'b0;  sat_q <= 1'b0;
      out_valid_q <= 1'b0;  t_q <= '0;  nlen_q <= '0;  dot_q <= '0;
      rad_q <= '0;  rem_q <= '0;  root_q <= '0;  cnt_q <= '0;
      den_q <= '0;  drem_q <= '0;  quo_q <= '0;
      for (int k = 0; k < 3; k++) begin
        orig_q[k] <= '0;  light_q[k] <= '0;  dir_q[k] <= '0;  normal_q[k] <= '0;
        albedo_q[k] <= '0;  color_q[k] <= '0;  p_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;  hit_q <= hit_d;  fast_q <= fast_d;  sat_q <= sat_d;
      out_valid_q <= out_valid_d;  t_q <= t_d;  nlen_q <= nlen_d;  dot_q <= dot_d;
      rad_q <= rad_d;  rem_q <= rem_d;  root_q <= root_d;  cnt_q <= cnt_d;
      den_q <= den_d;  drem_q <= drem_d;  quo_q <= quo_d;
      for (int k = 0; k < 3; k++) begin
        orig_q[k] <= orig_d[k];  light_q[k] <= light_d[k];  dir_q[k] <= dir_d[k];
        normal_q[k] <= normal_d[k];  albedo_q[k] <= albedo_d[k];
        color_q[k] <= color_d[k];  p_q[k] <= p_d[k];
      end
    end
  end
endmodule
